// File: rtl/crypt_result_fifo.sv
// Result-capture FIFO for the RSA datapath: end-of-conversion results in,
// show-ahead valid/ready readout, count/full/empty status, sticky overflow.
//
// Ports:
//   clk, rstb (sync, active-low)   clock and reset
//   en, eoc, r_i                   capture strobe (gated by en) and result word
//   flush                          clears all stored entries (ovf kept)
//   c_ex, c_valid, c_ready         head word (0 when empty) and handshake
//   count, full, empty             occupancy status
//   ovf, ovf_clr                   sticky overflow flag and its clear
module crypt_result_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             eoc,
    input  logic [WIDTH-1:0] r_i,
    input  logic             flush,
    input  logic             c_ready,
    output logic [WIDTH-1:0] c_ex,
    output logic             c_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic OVW = (OVERWRITE != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic push, pop, wr_ok, ovr, mem_we;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign c_valid = ~empty;
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign c_ex    = c_valid ? mem_q[rd_ptr_q] : '0;

    assign push = en & eoc;
    assign pop  = c_valid & c_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_we   = 1'b0;
        // A pop frees a slot in the same cycle, so push+pop while full is legal.
        wr_ok    = push & (~full | pop);
        ovr      = push & full & ~pop;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovr      = 1'b0;
        end else begin
            // Overwrite mode: wr_ptr == rd_ptr when full, so the oldest
            // word is replaced and both pointers step together.
            mem_we = wr_ok | (ovr & OVW);
            if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop | (ovr & OVW)) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_ok & ~pop) count_d = count_q + 1'b1;
            else if (pop & ~wr_ok) count_d = count_q - 1'b1;
        end
        // A new overflow wins over a same-cycle clear.
        if (ovr) ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
        else ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (rstb && mem_we) mem_q[wr_ptr_q] <= r_i;
    end

endmodule
